pl_clk_activity_monitor: RTL and testbench
==========================================

# pl_clk_activity_monitor

Synthesizable, parametrised multi-channel clock/reset activity monitor for the extensible platform PL region. Counts rising edges on NUM_CH pre-synchronised monitor inputs (clock-divider toggles or reset levels) over a programmable window of pl_clk0 cycles. Reports per-channel edge counts and alive flags, plus a saturating count of pl_clk0 cycles since reset release. Replaces bench-only edge polling with a block usable in hardware and simulation alike.

## Interface
Parameters:
- NUM_CH, 4, number of monitored channels (1..32)
- WIN_CYCLES, 1024, window length in pl_clk0 cycles (>=2)
- CNT_W, 16, per-channel edge counter width
- MIN_EDGES, 1, edges per window required for ch_alive
- RST_CNT_W, 32, width of reset-release counter
- CONTINUOUS, 0, 1 = windows repeat back-to-back without start

Ports (one clock; reset is synchronous and active-high):
- pl_clk0  in  1  sole clock; all logic on rising edge
- pl_reset  in  1  synchronous, active-high reset
- ch_in  in  NUM_CH  monitor inputs, already synchronous to pl_clk0
- start  in  1  single-cycle request to begin one window (CONTINUOUS=0)
- busy  out  1  high in RUN and DONE
- done  out  1  one-cycle pulse, results valid
- edge_cnt  out  NUM_CH*CNT_W  latched counts; channel i at [i*CNT_W +: CNT_W]
- ch_alive  out  NUM_CH  latched edge_cnt[i] >= MIN_EDGES
- rst_release_cnt  out  RST_CNT_W  pl_clk0 cycles since pl_reset deassertion, saturating
- err_sticky  out  1  see Configuration

## Operation
- States: IDLE, RUN, DONE.
- IDLE: start=1 -> RUN; working counters and win_cnt cleared on entry. CONTINUOUS=1 -> RUN unconditionally.
- RUN: win_cnt increments 0..WIN_CYCLES-1; at WIN_CYCLES-1 -> DONE.
- DONE: lasts one cycle. Next state is RUN if CONTINUOUS=1, otherwise IDLE.
- Edge detect: prev[i] is registered every cycle in all states. It resets to 0. rise[i] = ch_in[i] & ~prev[i].
- rise is counted only in RUN cycles. No spurious edge is generated on RUN entry.
- Working counters saturate at 2^CNT_W-1. They never wrap.
- Edges arriving in DONE or IDLE cycles are not counted.
- start is ignored in RUN and DONE. start while pl_reset=1 is ignored.
- rst_release_cnt increments every cycle pl_reset=0. It saturates at all-ones.
- Reset values: state=IDLE, busy=0, done=0, edge_cnt=0, ch_alive=0, rst_release_cnt=0, err_sticky=0, prev=0.
- Reset mid-window aborts the window. Partial counts are discarded and no done is issued.

## Timing
- start high in cycle T -> RUN cycles T+1..T+WIN_CYCLES -> DONE in cycle T+WIN_CYCLES+1.
- In the DONE cycle, done=1 and edge_cnt/ch_alive are registered and hold the new values.
- Outputs hold until the next DONE or reset.
- CONTINUOUS=1: done period is WIN_CYCLES+1 cycles. First RUN starts the cycle after reset release.
- rst_release_cnt reads 1 in the first cycle after the pl_reset=0 edge has been sampled.
- No combinational paths from inputs to outputs.

## Configuration
- PL_CLK_MON_STICKY_ERR_EN defined: err_sticky is set in the DONE cycle if any ch_alive bit computes 0. It stays set until pl_reset.
- PL_CLK_MON_STICKY_ERR_EN undefined: err_sticky is tied to 0 and no error register is synthesised.

## Test plan
Default bench parameters: NUM_CH=4, WIN_CYCLES=16, CNT_W=8, MIN_EDGES=2, CONTINUOUS=0.
- Basic counts: ch0 toggles every cycle, ch1 period 4, ch2 held 0, ch3 held 1; pulse start -> edge_cnt = {0,0,4,8} (ch3..ch0), ch_alive=4'b0011.
- Latency: start in cycle 100 -> done high only in cycle 117; busy high in cycles 101..117; start re-pulsed in cycle 105 has no effect.
- Saturation: CNT_W=2, ch0 toggling every cycle -> edge_cnt[0]=3, no wrap to 0.
- Reset mid-window: assert pl_reset at RUN cycle 8 -> next cycle state IDLE, done=0, edge_cnt=0, rst_release_cnt=0; after release, rst_release_cnt counts 1,2,3...
- Continuous mode: CONTINUOUS=1, ch1 period 4 -> done pulses every 17 cycles; edge_cnt[1] is 4 in each window; an edge placed in a DONE cycle is not counted.
- Sticky error (macro defined): window 1 has ch2 stuck -> err_sticky=1 at DONE. Window 2 has all channels alive -> err_sticky stays 1. With the macro undefined -> err_sticky=0 throughout.

Source files
------------

// File: rtl/pl_clk_activity_monitor.sv
// Multi-channel clock/reset activity monitor: counts rising edges per channel over a window of pl_clk0 cycles.
// Latency: start in cycle T gives done (with edge_cnt/ch_alive updated) in cycle T+WIN_CYCLES+1.
// Backpressure: none; start is ignored in RUN/DONE, and results hold until the next done or reset.
//
// Ports:
//   pl_clk0          sole clock
//   pl_reset         synchronous active-high reset
//   ch_in            monitor inputs, already synchronous to pl_clk0
//   start            single-cycle request for one window (ignored when CONTINUOUS=1)
//   busy             high in RUN and DONE
//   done             one-cycle pulse, results valid
//   edge_cnt         latched per-channel counts, channel i at [i*CNT_W +: CNT_W]
//   ch_alive         latched edge_cnt[i] >= MIN_EDGES
//   rst_release_cnt  saturating pl_clk0 cycles since pl_reset deassertion
//   err_sticky       set when any channel was not alive at the end of a window
//
// Optional feature macro: PL_CLK_MON_STICKY_ERR_EN (enables the err_sticky register;
// without it err_sticky is tied low).
module pl_clk_activity_monitor #(
   parameter int NUM_CH     = 4,
   parameter int WIN_CYCLES = 1024,
   parameter int CNT_W      = 16,
   parameter int MIN_EDGES  = 1,
   parameter int RST_CNT_W  = 32,
   parameter int CONTINUOUS = 0
) (
   input  logic                      pl_clk0,
   input  logic                      pl_reset,
   input  logic [NUM_CH-1:0]         ch_in,
   input  logic                      start,
   output logic                      busy,
   output logic                      done,
   output logic [NUM_CH*CNT_W-1:0]   edge_cnt,
   output logic [NUM_CH-1:0]         ch_alive,
   output logic [RST_CNT_W-1:0]      rst_release_cnt,
   output logic                      err_sticky
);

   // win_cnt only spans 0..WIN_CYCLES-1
   localparam int WIN_W = (WIN_CYCLES > 2) ? $clog2(WIN_CYCLES) : 1;

   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

   state_t                  state_q;
   logic [WIN_W-1:0]        win_cnt_q;
   logic [NUM_CH-1:0]       prev_q;
   logic [CNT_W-1:0]        work_q [NUM_CH];
   logic [CNT_W-1:0]        work_d [NUM_CH];
   logic [NUM_CH-1:0]       alive_d;
   logic [NUM_CH-1:0]       rise;
   logic                    win_last;
   logic                    busy_q;
   logic                    done_q;
   logic [NUM_CH*CNT_W-1:0] edge_cnt_q;
   logic [NUM_CH-1:0]       alive_q;
   logic [RST_CNT_W-1:0]    rst_cnt_q;
   logic [RST_CNT_W-1:0]    rst_cnt_d;

   assign win_last = (win_cnt_q == WIN_W'(WIN_CYCLES - 1));

   // work_d is the counter value including this cycle's edge; it is what gets
   // latched on the last RUN cycle so the final edge of the window is not lost.
   always_comb begin
      rise = ch_in & ~prev_q;
      for (int i = 0; i < NUM_CH; i++) begin
         work_d[i] = work_q[i];
         if (rise[i] && (work_q[i] != {CNT_W{1'b1}})) begin
            work_d[i] = work_q[i] + CNT_W'(1);
         end
         alive_d[i] = (work_d[i] >= CNT_W'(MIN_EDGES));
      end
   end

   always_comb begin
      rst_cnt_d = rst_cnt_q;
      if (rst_cnt_q != {RST_CNT_W{1'b1}}) begin
         rst_cnt_d = rst_cnt_q + RST_CNT_W'(1);
      end
   end

   always_ff @(posedge pl_clk0) begin
      if (pl_reset) begin
         state_q    <= ST_IDLE;
         win_cnt_q  <= '0;
         prev_q     <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         edge_cnt_q <= '0;
         alive_q    <= '0;
         rst_cnt_q  <= '0;
         for (int i = 0; i < NUM_CH; i++) begin
            work_q[i] <= '0;
         end
      end else begin
         // prev tracks ch_in in every state so RUN entry never sees a stale 0
         prev_q    <= ch_in;
         rst_cnt_q <= rst_cnt_d;
         done_q    <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               win_cnt_q <= '0;
               for (int i = 0; i < NUM_CH; i++) begin
                  work_q[i] <= '0;
               end
               if (start || (CONTINUOUS != 0)) begin
                  state_q <= ST_RUN;
                  busy_q  <= 1'b1;
               end
            end
            ST_RUN: begin
               win_cnt_q <= win_cnt_q + WIN_W'(1);
               for (int i = 0; i < NUM_CH; i++) begin
                  work_q[i] <= work_d[i];
               end
               if (win_last) begin
                  state_q <= ST_DONE;
                  done_q  <= 1'b1;
                  alive_q <= alive_d;
                  for (int i = 0; i < NUM_CH; i++) begin
                     edge_cnt_q[i*CNT_W +: CNT_W] <= work_d[i];
                  end
               end
            end
            ST_DONE: begin
               // clearing here gives back-to-back windows a clean start
               win_cnt_q <= '0;
               for (int i = 0; i < NUM_CH; i++) begin
                  work_q[i] <= '0;
               end
               if (CONTINUOUS != 0) begin
                  state_q <= ST_RUN;
               end else begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign busy            = busy_q;
   assign done            = done_q;
   assign edge_cnt        = edge_cnt_q;
   assign ch_alive        = alive_q;
   assign rst_release_cnt = rst_cnt_q;

`ifdef PL_CLK_MON_STICKY_ERR_EN
   logic err_q;

   // set alongside the result latch so it is visible in the DONE cycle
   always_ff @(posedge pl_clk0) begin
      if (pl_reset) begin
         err_q <= 1'b0;
      end else if ((state_q == ST_RUN) && win_last && !(&alive_d)) begin
         err_q <= 1'b1;
      end
   end

   assign err_sticky = err_q;
`else
   assign err_sticky = 1'b0;
`endif

endmodule

// File: tb/tb_pl_clk_activity_monitor.sv
// Directed bench for pl_clk_activity_monitor: default window, saturating and continuous instances.
// Latency: results checked in the DONE cycle, start-to-done measured per cycle.
// Backpressure: not applicable; inputs driven #1 after each rising edge, outputs sampled there too.
module tb_pl_clk_activity_monitor;

   localparam int NUM_CH = 4;
   localparam int WIN    = 16;
   localparam int CNT_W  = 8;
   localparam int MIN_E  = 2;

`ifdef PL_CLK_MON_STICKY_ERR_EN
   localparam logic EXP_ERR = 1'b1;
`else
   localparam logic EXP_ERR = 1'b0;
`endif

   logic pl_clk0 = 1'b0;
   always #5 pl_clk0 = ~pl_clk0;

   logic              pl_reset;
   logic [NUM_CH-1:0] ch_in;
   logic              start;
   logic              start_c;

   logic                    busy, done, err_sticky;
   logic [NUM_CH*CNT_W-1:0] edge_cnt;
   logic [NUM_CH-1:0]       ch_alive;
   logic [31:0]             rst_release_cnt;

   logic                    busy_s, done_s, err_s;
   logic [NUM_CH*2-1:0]     edge_cnt_s;
   logic [NUM_CH-1:0]       ch_alive_s;
   logic [31:0]             rst_cnt_s;

   logic                    busy_c, done_c, err_c;
   logic [NUM_CH*CNT_W-1:0] edge_cnt_c;
   logic [NUM_CH-1:0]       ch_alive_c;
   logic [31:0]             rst_cnt_c;

   pl_clk_activity_monitor #(.NUM_CH(NUM_CH), .WIN_CYCLES(WIN), .CNT_W(CNT_W),
                             .MIN_EDGES(MIN_E), .RST_CNT_W(32), .CONTINUOUS(0)) u_dut (
      .pl_clk0(pl_clk0), .pl_reset(pl_reset), .ch_in(ch_in), .start(start),
      .busy(busy), .done(done), .edge_cnt(edge_cnt), .ch_alive(ch_alive),
      .rst_release_cnt(rst_release_cnt), .err_sticky(err_sticky));

   pl_clk_activity_monitor #(.NUM_CH(NUM_CH), .WIN_CYCLES(WIN), .CNT_W(2),
                             .MIN_EDGES(MIN_E), .RST_CNT_W(32), .CONTINUOUS(0)) u_sat (
      .pl_clk0(pl_clk0), .pl_reset(pl_reset), .ch_in(ch_in), .start(start),
      .busy(busy_s), .done(done_s), .edge_cnt(edge_cnt_s), .ch_alive(ch_alive_s),
      .rst_release_cnt(rst_cnt_s), .err_sticky(err_s));

   pl_clk_activity_monitor #(.NUM_CH(NUM_CH), .WIN_CYCLES(WIN), .CNT_W(CNT_W),
                             .MIN_EDGES(MIN_E), .RST_CNT_W(32), .CONTINUOUS(1)) u_cont (
      .pl_clk0(pl_clk0), .pl_reset(pl_reset), .ch_in(ch_in), .start(start_c),
      .busy(busy_c), .done(done_c), .edge_cnt(edge_cnt_c), .ch_alive(ch_alive_c),
      .rst_release_cnt(rst_cnt_c), .err_sticky(err_c));

   int   n_tests = 0;
   int   n_fail  = 0;
   int   gcyc    = 0;
   int   mode    = 0;
   logic ch0_force = 1'b0;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   // mode 0: ch0 toggles, ch1 period 4, ch2 stuck 0, ch3 stuck 1
   // mode 1: every channel toggles each cycle
   // mode 2: ch1 period 4, ch0 under direct control, ch2/ch3 low
   task automatic drive_ch();
      logic c1;
      c1 = ((gcyc % 4) >= 2);
      case (mode)
         0:       ch_in = {1'b1, 1'b0, c1, gcyc[0]};
         1:       ch_in = {NUM_CH{gcyc[0]}};
         default: ch_in = {2'b00, c1, ch0_force};
      endcase
   endtask

   task automatic tick();
      @(posedge pl_clk0);
      #1;
      gcyc++;
      drive_ch();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int waited;
      int n_done;
      pl_reset = 1'b1;
      start    = 1'b0;
      start_c  = 1'b0;
      ch_in    = '0;
      repeat (3) tick();

      // reset state
      chk("rst_busy",      busy, 0);
      chk("rst_done",      done, 0);
      chk("rst_edge_cnt",  edge_cnt, 0);
      chk("rst_alive",     ch_alive, 0);
      chk("rst_rel_cnt",   rst_release_cnt, 0);
      chk("rst_err",       err_sticky, 0);
      chk("rst_cont_busy", busy_c, 0);

      pl_reset = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         tick();
         chk("rel_cnt_count", rst_release_cnt, k);
      end

      // basic counts + latency; start re-pulsed in cycle S+5
      repeat (2) tick();
      start = 1'b1;
      tick();
      for (int j = 1; j <= 19; j++) begin
         chk("lat_busy", busy, (j <= 17));
         chk("lat_done", done, (j == 17));
         if (j == 17) begin
            chk("basic_edge_cnt", edge_cnt, 32'h0000_0408);
            chk("basic_alive",    ch_alive, 4'b0011);
            chk("sat_edge_cnt",   edge_cnt_s, 8'h0F);
            chk("sat_alive",      ch_alive_s, 4'b0011);
            chk("win1_err",       err_sticky, EXP_ERR);
         end
         start = (j == 5);
         tick();
      end
      start = 1'b0;
      chk("hold_edge_cnt", edge_cnt, 32'h0000_0408);
      chk("hold_done",     done, 0);

      // second window, all channels alive; error stays sticky
      mode = 1;
      tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      waited = 0;
      while (done !== 1'b1 && waited < 40) begin
         tick();
         waited++;
      end
      chk("win2_latency",  waited, 16);
      chk("win2_edge_cnt", edge_cnt, 32'h0808_0808);
      chk("win2_alive",    ch_alive, 4'b1111);
      chk("win2_err",      err_sticky, EXP_ERR);

      // reset mid-window at RUN cycle 8
      mode = 0;
      tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (7) tick();
      pl_reset = 1'b1;
      tick();
      chk("abort_busy",     busy, 0);
      chk("abort_done",     done, 0);
      chk("abort_edge_cnt", edge_cnt, 0);
      chk("abort_alive",    ch_alive, 0);
      chk("abort_rel_cnt",  rst_release_cnt, 0);
      chk("abort_err",      err_sticky, 0);
      pl_reset = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         tick();
         chk("abort_rel_count", rst_release_cnt, k);
      end
      n_done = 0;
      for (int k = 0; k < 25; k++) begin
         tick();
         if (done === 1'b1) n_done++;
      end
      chk("abort_no_done", n_done, 0);

      // start during reset is ignored
      pl_reset = 1'b1;
      start    = 1'b1;
      tick();
      pl_reset = 1'b0;
      start    = 1'b0;
      tick();
      chk("start_in_rst_busy1", busy, 0);
      tick();
      chk("start_in_rst_busy2", busy, 0);

      // continuous instance: period and DONE-cycle edge exclusion
      mode      = 2;
      ch0_force = 1'b0;
      tick();
      waited = 0;
      while (done_c !== 1'b1 && waited < 40) begin
         tick();
         waited++;
      end
      chk("cont_first_done", done_c, 1);
      chk("cont_first_cnt1", edge_cnt_c[1*CNT_W +: CNT_W], 4);
      for (int k = 1; k <= 34; k++) begin
         ch0_force = (k == 17);
         tick();
         chk("cont_done", done_c, (k == 17 || k == 34));
         chk("cont_busy", busy_c, 1);
         if (k == 17 || k == 34) begin
            chk("cont_cnt1", edge_cnt_c[1*CNT_W +: CNT_W], 4);
            chk("cont_cnt0", edge_cnt_c[0*CNT_W +: CNT_W], 0);
            chk("cont_err",  err_c, EXP_ERR);
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
